// File: rtl/poly_horner_eval.sv
// Sequential signed quadratic evaluator A*X^2 + B*X + C using the Horner form ((A*X)+B)*X + C.
// One shared multiplier and adder are sequenced by a small FSM; done is flagged by a one-cycle pulse.
module poly_horner_eval #(
  parameter int XW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          START,
  input  logic [XW-1:0] X,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [DW-1:0] C,
  output logic [DW-1:0] Resultado,
  output logic          Overflow,
  output logic          finished
);

  typedef enum logic [2:0] {
    IDLE, LOAD, MUL1, ADD1, MUL2, ADD2, DONE
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0]   x_r, h_r, b_r, c_r;
  logic            ovf;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   add_op;
  logic [DW-1:0]   sum;
  logic            mul_ovf, add_ovf;

  // The product fits in DW bits only if its top DW+1 bits are all equal
  assign prod    = $signed({{DW{h_r[DW-1]}}, h_r}) * $signed({{DW{x_r[DW-1]}}, x_r});
  assign mul_ovf = !((&prod[2*DW-1:DW-1]) || !(|prod[2*DW-1:DW-1]));

  assign add_op  = (state == ADD2) ? c_r : b_r;
  assign sum     = h_r + add_op;
  assign add_ovf = (h_r[DW-1] == add_op[DW-1]) && (sum[DW-1] != h_r[DW-1]);

  assign finished = (state == DONE);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = LOAD;
      LOAD:    state_nxt = MUL1;
      MUL1:    state_nxt = ADD1;
      ADD1:    state_nxt = MUL2;
      MUL2:    state_nxt = ADD2;
      ADD2:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // H accumulates the Horner partial result; Resultado only moves on the final add
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      x_r       <= '0;
      h_r       <= '0;
      b_r       <= '0;
      c_r       <= '0;
      ovf       <= 1'b0;
      Resultado <= '0;
      Overflow  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          x_r <= {{(DW-XW){X[XW-1]}}, X};
          h_r <= A;
          b_r <= B;
          c_r <= C;
          ovf <= 1'b0;
        end
        MUL1, MUL2: begin
          h_r <= prod[DW-1:0];
          ovf <= ovf | mul_ovf;
        end
        ADD1: begin
          h_r <= sum;
          ovf <= ovf | add_ovf;
        end
        ADD2: begin
          h_r       <= sum;
          ovf       <= ovf | add_ovf;
          Resultado <= sum;
          Overflow  <= ovf | add_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_horner_eval.sv
// Randomized scoreboard bench for poly_horner_eval: stimulus pushes expected results,
// a negedge monitor pops and compares value, overflow flag and completion cycle.
module tb_poly_horner_eval;

  logic        clk = 1'b0;
  logic        RST;
  logic        START;
  logic [7:0]  X;
  logic [15:0] A, B, C;
  logic [15:0] Resultado;
  logic        Overflow;
  logic        finished;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];

  poly_horner_eval #(.XW(8), .DW(16)) dut (
    .clk       (clk),
    .RST       (RST),
    .START     (START),
    .X         (X),
    .A         (A),
    .B         (B),
    .C         (C),
    .Resultado (Resultado),
    .Overflow  (Overflow),
    .finished  (finished)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic longint wrap16(input longint v);
    logic signed [15:0] t;
    t = v[15:0];
    return longint'(t);
  endfunction

  function automatic logic out_range(input longint v);
    return (v > 32767) || (v < -32768);
  endfunction

  // Reference: evaluate Horner steps with wide integers, flagging any step outside 16-bit range
  function automatic void model(input logic [7:0] x, input logic [15:0] a, b, c,
                                output logic [15:0] res, output logic ovf);
    longint xv, h, t;
    xv  = longint'($signed(x));
    h   = longint'($signed(a));
    ovf = 1'b0;
    t = h * xv;                       ovf |= out_range(t); h = wrap16(t);
    t = h + longint'($signed(b));     ovf |= out_range(t); h = wrap16(t);
    t = h * xv;                       ovf |= out_range(t); h = wrap16(t);
    t = h + longint'($signed(c));     ovf |= out_range(t); h = wrap16(t);
    res = h[15:0];
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic push_expect(input logic [7:0] x, input logic [15:0] a, b, c, input int due);
    exp_t e;
    model(x, a, b, c, e.res, e.ovf);
    e.due = due;
    sb.push_back(e);
  endtask

  // Single run: START for one edge, inputs scrambled once LOAD has sampled them
  task automatic apply_stimulus(input logic [7:0] x, input logic [15:0] a, b, c);
    int c0;
    X = x; A = a; B = b; C = c;
    START = 1'b1;
    c0 = cycle;
    push_expect(x, a, b, c, c0 + 6);
    @(negedge clk);
    START = 1'b0;
    @(negedge clk);
    X = 8'($urandom); A = 16'($urandom); B = 16'($urandom); C = 16'($urandom);
    repeat (5) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (finished) begin
      if (sb.size() == 0) begin
        check_output("unexpected_finished", 32'(finished), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("resultado", 32'(Resultado), 32'(e.res));
        check_output("overflow", 32'(Overflow), 32'(e.ovf));
        check_output("finish_cycle", 32'(cycle), 32'(e.due));
      end
    end
  end

  initial begin
    int c0;
    RST = 1'b0; START = 1'b0; X = '0; A = '0; B = '0; C = '0;
    repeat (2) @(negedge clk);
    check_output("reset_resultado", 32'(Resultado), 32'd0);
    check_output("reset_overflow", 32'(Overflow), 32'd0);
    check_output("reset_finished", 32'(finished), 32'd0);
    RST = 1'b1;
    @(negedge clk);

    apply_stimulus(8'hFE, 16'h0001, 16'h0004, 16'h0005);
    apply_stimulus(8'h03, 16'h0002, 16'hFFFF, 16'h0007);
    apply_stimulus(8'h10, 16'h0100, 16'h0000, 16'h0000);
    apply_stimulus(8'hFE, 16'h0001, 16'h0004, 16'h0005);
    apply_stimulus(8'h10, 16'h0100, 16'h0000, 16'h0005);

    // Abort a run in MUL2: outputs must clear and no finished pulse may appear
    X = 8'hFE; A = 16'h0001; B = 16'h0004; C = 16'h0005;
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    repeat (3) @(negedge clk);
    RST = 1'b0;
    #1;
    check_output("abort_resultado", 32'(Resultado), 32'd0);
    check_output("abort_overflow", 32'(Overflow), 32'd0);
    check_output("abort_finished", 32'(finished), 32'd0);
    repeat (3) @(negedge clk);
    RST = 1'b1;
    repeat (8) @(negedge clk);
    apply_stimulus(8'hFE, 16'h0001, 16'h0004, 16'h0005);

    // START held high: three back-to-back runs, A disturbed after each LOAD
    X = 8'hFE; A = 16'h0001; B = 16'h0004; C = 16'h0005;
    START = 1'b1;
    c0 = cycle;
    for (int r = 0; r < 3; r++) begin
      push_expect(8'hFE, 16'h0001, 16'h0004, 16'h0005, c0 + 6 + 7 * r);
      repeat (2) @(negedge clk);
      A = 16'($urandom);
      repeat (5) @(negedge clk);
      A = 16'h0001;
    end
    START = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0)
        apply_stimulus(8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      else
        apply_stimulus(8'($urandom_range(255)), 16'($signed(7'($urandom))),
                       16'($signed(12'($urandom))), 16'($urandom));
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check_output("pending_results", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
